// File: rtl/matrix_scalar_divider.sv
// Divides each signed 8-bit element of a flattened 5x5 matrix by a signed 8-bit
// scalar, one element at a time, through a single bit-serial restoring divider.
module matrix_scalar_divider #(
  parameter int N_ELEM = 25,
  parameter int W      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [N_ELEM*W-1:0]   matriz_entrada,
  input  logic [W-1:0]          escalar,
  output logic                  busy,
  output logic                  done,
  output logic                  div_zero,
  output logic                  ovf,
  output logic [N_ELEM*W-1:0]   matriz_saida
);

  localparam int KW = $clog2(N_ELEM);
  localparam int IW = $clog2(W);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DIV   = 2'd2,
    S_STORE = 2'd3
  } state_t;

  // Two's-complement magnitude; the most negative value maps to 2^(W-1).
  function automatic logic [W-1:0] abs_mag(input logic [W-1:0] x);
    logic [W-1:0] r;
    if (x[W-1]) begin
      r = W'(~x + {{(W-1){1'b0}}, 1'b1});
    end else begin
      r = x;
    end
    return r;
  endfunction

  // Re-applies the sign to a magnitude quotient; MSB of the result flags saturation.
  function automatic logic [W:0] signed_quotient(input logic [W-1:0] mag, input logic neg);
    logic [W:0] r;
    if (neg) begin
      r = {1'b0, W'(~mag + {{(W-1){1'b0}}, 1'b1})};
    end else if (mag[W-1]) begin
      r = {1'b1, 1'b0, {(W-1){1'b1}}};
    end else begin
      r = {1'b0, mag};
    end
    return r;
  endfunction

  state_t                 state_q, state_d;
  logic [N_ELEM*W-1:0]    mat_q, mat_d;
  logic [W-1:0]           esc_q, esc_d;
  logic [KW-1:0]          k_q, k_d;
  logic [IW-1:0]          iter_q, iter_d;
  logic [W-1:0]           dvd_q, dvd_d;
  logic [W-1:0]           dvs_q, dvs_d;
  logic [W-1:0]           rem_q, rem_d;
  logic [N_ELEM*W-1:0]    buf_q, buf_d;
  logic [N_ELEM*W-1:0]    out_q, out_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   dz_q, dz_d;
  logic                   ovf_q, ovf_d;

  logic [W:0]             trial_s;
  logic [W:0]             diff_s;
  logic                   trial_ge_s;
  logic [W-1:0]           elem_s;
  logic [W:0]             quot_s;
  logic [KW+2:0]          slot_s;

  assign slot_s     = {k_q, 3'b000};
  assign elem_s     = mat_q[slot_s +: W];
  assign trial_s    = {rem_q, dvd_q[W-1]};
  assign diff_s     = trial_s - {1'b0, dvs_q};
  assign trial_ge_s = (trial_s >= {1'b0, dvs_q});
  assign quot_s     = signed_quotient(dvd_q, elem_s[W-1] ^ esc_q[W-1]);

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mat_q   <= '0;
      esc_q   <= '0;
      k_q     <= '0;
      iter_q  <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      buf_q   <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mat_q   <= mat_d;
      esc_q   <= esc_d;
      k_q     <= k_d;
      iter_q  <= iter_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      buf_q   <= buf_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    mat_d   = mat_q;
    esc_d   = esc_q;
    k_d     = k_q;
    iter_d  = iter_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    buf_d   = buf_q;
    out_d   = out_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dz_d    = dz_q;
    ovf_d   = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mat_d = matriz_entrada;
          esc_d = escalar;
          k_d   = '0;
          dz_d  = 1'b0;
          ovf_d = 1'b0;
          if (escalar == {W{1'b0}}) begin
            out_d   = '0;
            dz_d    = 1'b1;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            busy_d  = 1'b1;
            state_d = S_LOAD;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_LOAD: begin
        dvd_d   = abs_mag(elem_s);
        dvs_d   = abs_mag(esc_q);
        rem_d   = '0;
        iter_d  = '0;
        state_d = S_DIV;
      end

      S_DIV: begin
        // Quotient bits shift in from the right as dividend bits leave on the left.
        if (trial_ge_s) begin
          rem_d = diff_s[W-1:0];
          dvd_d = {dvd_q[W-2:0], 1'b1};
        end else begin
          rem_d = trial_s[W-1:0];
          dvd_d = {dvd_q[W-2:0], 1'b0};
        end
        iter_d = iter_q + {{(IW-1){1'b0}}, 1'b1};
        if (iter_q == IW'(W-1)) begin
          state_d = S_STORE;
        end else begin
          state_d = S_DIV;
        end
      end

      S_STORE: begin
        buf_d[slot_s +: W] = quot_s[W-1:0];
        if (quot_s[W]) begin
          ovf_d = 1'b1;
        end else begin
          ovf_d = ovf_q;
        end
        if (k_q == KW'(N_ELEM-1)) begin
          out_d   = buf_d;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          k_d     = k_q + {{(KW-1){1'b0}}, 1'b1};
          state_d = S_LOAD;
        end
      end

      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign div_zero     = dz_q;
  assign ovf          = ovf_q;
  assign matriz_saida = out_q;

endmodule

// File: tb/tb_matrix_scalar_divider.sv
// Bench for matrix_scalar_divider: a timing-level reference model checked every
// cycle, plus hand-computed literal expectations for the directed cases.
module tb_matrix_scalar_divider;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [199:0] mat_in;
  logic [7:0]   esc;
  logic         busy, done, div_zero, ovf;
  logic [199:0] mat_out;

  int errors = 0;
  int checks = 0;

  matrix_scalar_divider dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .matriz_entrada (mat_in),
    .escalar        (esc),
    .busy           (busy),
    .done           (done),
    .div_zero       (div_zero),
    .ovf            (ovf),
    .matriz_saida   (mat_out)
  );

  always #5 clk = ~clk;

  // Reference model: the operation takes 250 edges after acceptance, element k
  // lands at 10(k+1), results are plain truncating integer division with +128 clipped.
  logic         m_busy, m_done, m_dz, m_ovf;
  logic [199:0] m_out, m_pend;
  bit           m_sat [25];
  int           m_el;

  task automatic model_step();
    int a, b, q;
    if (!rst_n) begin
      m_busy = 1'b0; m_done = 1'b0; m_dz = 1'b0; m_ovf = 1'b0;
      m_out = '0; m_pend = '0; m_el = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_el++;
        if ((m_el % 10) == 0 && m_sat[m_el/10 - 1]) m_ovf = 1'b1;
        if (m_el == 250) begin
          m_out  = m_pend;
          m_done = 1'b1;
          m_busy = 1'b0;
        end
      end else if (start) begin
        m_dz  = 1'b0;
        m_ovf = 1'b0;
        if (esc == 8'd0) begin
          m_out  = '0;
          m_dz   = 1'b1;
          m_done = 1'b1;
        end else begin
          m_busy = 1'b1;
          m_el   = 0;
          b = int'($signed(esc));
          for (int k = 0; k < 25; k++) begin
            a = int'($signed(mat_in[8*k +: 8]));
            q = a / b;
            m_sat[k] = (q > 127);
            if (q > 127) q = 127;
            m_pend[8*k +: 8] = 8'(q);
          end
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  task automatic chk(input string name, input logic [199:0] got, input logic [199:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    if (rst_n === 1'b1 || rst_n === 1'b0) begin
      chk("busy", {199'd0, busy}, {199'd0, m_busy});
      chk("done", {199'd0, done}, {199'd0, m_done});
      chk("div_zero", {199'd0, div_zero}, {199'd0, m_dz});
      chk("ovf", {199'd0, ovf}, {199'd0, m_ovf});
      chk("matriz_saida", mat_out, m_out);
    end
  end

  function automatic logic [199:0] fill(input logic [7:0] v);
    return {25{v}};
  endfunction

  task automatic run_op(input logic [199:0] m, input logic [7:0] e);
    @(negedge clk);
    mat_in = m;
    esc    = e;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("done_timeout", {199'd0, done}, {199'd0, 1'b1});
  endtask

  logic [199:0] v;
  int           n;

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    mat_in = '0;
    esc    = 8'd0;
    repeat (3) @(negedge clk);
    chk("reset_busy", {199'd0, busy}, 200'd0);
    chk("reset_out", mat_out, 200'd0);
    rst_n = 1'b1;

    // All 100 / 7 -> 14
    run_op(fill(8'd100), 8'd7);
    wait_done(n);
    chk("t1_latency", 200'(n), 200'd250);
    chk("t1_all14", mat_out, fill(8'd14));
    chk("t1_flags", {198'd0, div_zero, ovf}, 200'd0);

    // Signed mix (10k-120) / -7
    for (int k = 0; k < 25; k++) v[8*k +: 8] = 8'(10*k - 120);
    run_op(v, 8'hF9);
    wait_done(n);
    chk("t2_k0", 200'(mat_out[7:0]), 200'd17);
    chk("t2_k12", 200'(mat_out[103:96]), 200'd0);
    chk("t2_k24", 200'(mat_out[199:192]), 200'hEF);

    // Zero divisor, then a normal start clears div_zero
    run_op(fill(8'd5), 8'd0);
    chk("t3_done", {198'd0, done, div_zero}, 200'd3);
    chk("t3_busy", {199'd0, busy}, 200'd0);
    chk("t3_out", mat_out, 200'd0);
    run_op(fill(8'd9), 8'd3);
    chk("t3_dz_clear", {198'd0, busy, div_zero}, 200'd2);
    wait_done(n);
    chk("t3_all3", mat_out, fill(8'd3));

    // Saturation -128 / -1, then / 1
    v = '0;
    v[7:0]  = 8'h80;
    v[15:8] = 8'd127;
    run_op(v, 8'hFF);
    wait_done(n);
    chk("t4_sat", 200'(mat_out[15:0]), 200'h817F);
    chk("t4_ovf", {199'd0, ovf}, 200'd1);
    chk("t4_rest", 200'(mat_out[199:16]), 200'd0);
    run_op(v, 8'd1);
    wait_done(n);
    chk("t4b_vals", 200'(mat_out[15:0]), 200'h7F80);
    chk("t4b_ovf", {199'd0, ovf}, 200'd0);

    // Start during busy ignored; start in done cycle accepted
    run_op(fill(8'd50), 8'd5);
    repeat (48) @(negedge clk);
    mat_in = fill(8'd20);
    esc    = 8'd3;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    wait_done(n);
    chk("t5_snapshot", mat_out, fill(8'd10));
    mat_in = fill(8'hC4);
    esc    = 8'd6;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    chk("t5_b2b_busy", {199'd0, busy}, 200'd1);
    wait_done(n);
    chk("t5_b2b_latency", 200'(n), 200'd250);
    chk("t5_b2b_vals", mat_out, fill(8'hF6));

    // Reset mid-operation
    run_op(fill(8'd100), 8'd7);
    repeat (99) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_out", {mat_out[198:0], busy}, 200'd0);
    chk("t6_rst_done", {198'd0, done, div_zero}, 200'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("t6_no_done", {199'd0, done}, 200'd0);
    run_op(fill(8'hF7), 8'd2);
    wait_done(n);
    chk("t6_all_m4", mat_out, fill(8'hFC));
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/matrix_scalar_divider.md
Name: matrix_scalar_divider

Overview:
- Sequential inverse of the matrix-by-scalar multiply path.
- Divides each of the 25 signed 8-bit elements of a flattened 5x5 matrix by a signed 8-bit scalar.
- Uses one shared, bit-serial restoring divider, so it replaces 25 combinational dividers.
- Sits in the coprocessor operation set beside the scalar multiplier and uses the same flattened matrix format.

Parameters:
- N_ELEM, 25, number of matrix elements processed.
- W, 8, element and scalar width in bits.

Ports:
- clk  in  1  system clock; everything is rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- matriz_entrada  in  200  flattened matrix. Element k occupies [8k +: 8], with k = linha + 5*coluna.
- escalar  in  8  signed divisor.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle completion pulse.
- div_zero  out  1  set when the divisor was zero.
- ovf  out  1  set when any quotient saturated.
- matriz_saida  out  200  flattened signed quotients, same layout as matriz_entrada.

Behaviour:
- Reset (rst_n low, asynchronous): FSM goes to IDLE. busy, done, div_zero, ovf and matriz_saida are all 0. Internal buffer and counters are cleared.
- Reset mid-operation: aborts immediately. No done pulse, outputs are zero, and the next start after release works normally.
- FSM states are IDLE, LOAD, DIV, STORE.
- IDLE, start=1 sampled at edge E0:
  - Snapshot matriz_entrada and escalar into internal registers. Later input changes have no effect.
  - Clear div_zero and ovf. Set element index k=0.
- IDLE, start=1, escalar==0 at edge E0:
  - Stay in IDLE; busy stays 0.
  - At E0: matriz_saida <= 0, div_zero <= 1, done <= 1.
- IDLE, start=1, escalar!=0 at edge E0:
  - busy <= 1, go to LOAD.
- LOAD (1 cycle):
  - Take |element k| and |escalar| as 8-bit unsigned magnitudes (|-128| = 128).
  - Clear the partial remainder and set the iteration count to 0. Go to DIV.
- DIV (exactly 8 cycles): one restoring-division step per cycle, MSB first. Then go to STORE.
- STORE (1 cycle):
  - Apply the sign: negate the magnitude quotient if the element and escalar signs differ.
  - Saturation: a result of +128 (only -128 / -1) is written as +127 and sets ovf.
  - Write the quotient into internal buffer slot k. Discard the remainder.
  - Quotient truncates toward zero, matching Verilog signed "/".
  - If k < 24: k++, go to LOAD.
  - If k == 24: copy the buffer to matriz_saida, set done <= 1 and busy <= 0, go to IDLE.
- Latency: element k is stored at edge E0 + 10(k+1). done is registered at E0+250 and high for the cycle that follows.
- matriz_saida changes only when done is set. It holds its value until the next completion or reset, and is never partially updated.
- done is high for exactly one cycle; it is cleared on the next edge unless a new zero-divisor start sets it again.
- div_zero and ovf hold until the next accepted start.
- start while busy=1 is ignored; nothing is queued.
- start during the done cycle: FSM is already in IDLE, so the start is accepted (back-to-back operation allowed).
- |element| / |escalar| never exceeds 128, so the only overflow case is -128 / -1.

Test Plan:
- All elements 100, escalar 7, start at E0: busy=1 from E0 to E0+250; done pulses after E0+250; all quotients 14; div_zero=0, ovf=0.
- Signed mix, element k = 10k-120, escalar -7: each output equals trunc((10k-120)/-7). For example, k=0 gives 17, k=12 gives 0, k=24 gives -17; matriz_saida checked against a reference model.
- escalar 0, start: done=1, div_zero=1, matriz_saida=0 after one edge; busy stays 0; a following start with escalar 3 clears div_zero.
- Element 0 = -128, element 1 = 127, rest 0, escalar -1: outputs 127, -127, 0...; ovf=1. Repeat with escalar 1: outputs -128, 127; ovf=0.
- Pulse start again at E0+50 with different matriz_entrada and escalar during busy: ignored, result matches the first snapshot. Assert start during the done cycle: a second operation runs, completing 250 cycles later.
- Drop rst_n low at E0+100: outputs 0 immediately, no done. After release, a new start with escalar 2 and all elements -9 gives all -4 after 250 cycles.
